// File: rtl/fpga_v2.sv
// fpga_v2: 32-cell LUT4 fabric with 20 tristate pads, configured through a 1480-bit serial chain.
// Optional macro FPGAV2_CELL_FF_EN builds the per-cell output flip-flops (bit 40 of each cell).
`timescale 1ns/1ps
module fpga_v2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_clk,
    input  logic        prog_en,
    input  logic        prog_in,
    output logic        prog_out,
    inout  wire  [19:0] io
);

    localparam int unsigned CFG_W    = 1480;
    localparam int unsigned N_CELLS  = 32;
    localparam int unsigned CELL_W   = 41;
    localparam int unsigned N_PADS   = 20;
    localparam int unsigned PAD_W    = 7;
    localparam int unsigned PAD_BASE = 1312;
    localparam int unsigned SEL_W    = 6;

    logic [CFG_W-1:0]   r_cfg;
    logic [N_CELLS-1:0] w_cell_out;
    logic [63:0]        w_src;

    // Configuration chain: bit 0 leaves first, new bits enter at the top.
    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            r_cfg <= '0;
        end else if (prog_en) begin
            r_cfg <= {prog_in, r_cfg[CFG_W-1:1]};
        end
    end

    assign prog_out = r_cfg[0];

    // Routing sources: 0-19 pads, 20-51 cell outputs, 52-63 constant 0.
    assign w_src = {12'd0, w_cell_out, io};

    for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
        logic [15:0]      w_truth;
        logic [SEL_W-1:0] w_sel0;
        logic [SEL_W-1:0] w_sel1;
        logic [SEL_W-1:0] w_sel2;
        logic [SEL_W-1:0] w_sel3;
        logic [3:0]       w_idx;
        logic             w_lut;

        assign w_truth = r_cfg[CELL_W*k      +: 16];
        assign w_sel0  = r_cfg[CELL_W*k + 16 +: SEL_W];
        assign w_sel1  = r_cfg[CELL_W*k + 22 +: SEL_W];
        assign w_sel2  = r_cfg[CELL_W*k + 28 +: SEL_W];
        assign w_sel3  = r_cfg[CELL_W*k + 34 +: SEL_W];

        assign w_idx = {w_src[w_sel3], w_src[w_sel2], w_src[w_sel1], w_src[w_sel0]};
        assign w_lut = w_truth[w_idx];

`ifdef FPGAV2_CELL_FF_EN
        logic w_reg_sel;
        logic r_ff;

        assign w_reg_sel = r_cfg[CELL_W*k + 40];

        // Flops hold while the chain shifts so a design starts from its reset state
        // once programming ends; combinational outputs are parked at 0 to keep
        // half-loaded bitstreams from forming oscillating loops.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ff <= 1'b0;
            end else if (!prog_en) begin
                r_ff <= w_lut;
            end
        end

        assign w_cell_out[k] = w_reg_sel ? r_ff : (w_lut & ~prog_en);
`else
        assign w_cell_out[k] = w_lut & ~prog_en;
`endif
    end

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        logic [SEL_W-1:0] w_osel;
        logic             w_oe;

        assign w_osel = r_cfg[PAD_BASE + PAD_W*p +: SEL_W];
        assign w_oe   = r_cfg[PAD_BASE + PAD_W*p + 6];

        assign io[p] = (w_oe && !prog_en) ? w_src[w_osel] : 1'bz;
    end

endmodule

// File: tb/tb_fpga_v2.sv
// tb_fpga_v2: directed bench for fpga_v2 -- chain readback, XOR, 4-bit adder, pad disable, reset.
// Pads carry pull-ups, so a released pad reads 1; hi-Z checks use configurations that would drive 0.
`timescale 1ns/1ps
module tb_fpga_v2;

    logic        clk;
    logic        rst;
    logic        prog_clk;
    logic        prog_en;
    logic        prog_in;
    logic        prog_out;
    wire  [19:0] io;

    logic [19:0]   tb_drv;
    logic [19:0]   tb_oe;
    logic [1479:0] img;

    int n_tests;
    int n_fail;

    fpga_v2 dut (
        .clk      (clk),
        .rst      (rst),
        .prog_clk (prog_clk),
        .prog_en  (prog_en),
        .prog_in  (prog_in),
        .prog_out (prog_out),
        .io       (io)
    );

    for (genvar g = 0; g < 20; g++) begin : g_tb_pad
        assign io[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
        pullup (io[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
    endtask

    task automatic set_cell(input int unsigned k, input logic [15:0] t,
                            input int unsigned s0, input int unsigned s1,
                            input int unsigned s2, input int unsigned s3,
                            input logic r);
        logic [5:0] v0, v1, v2, v3;
        v0 = 6'(s0); v1 = 6'(s1); v2 = 6'(s2); v3 = 6'(s3);
        img[41*k      +: 16] = t;
        img[41*k + 16 +: 6]  = v0;
        img[41*k + 22 +: 6]  = v1;
        img[41*k + 28 +: 6]  = v2;
        img[41*k + 34 +: 6]  = v3;
        img[41*k + 40]       = r;
    endtask

    task automatic set_pad(input int unsigned p, input int unsigned sel, input logic oe);
        logic [5:0] v;
        v = 6'(sel);
        img[1312 + 7*p +: 6] = v;
        img[1312 + 7*p + 6]  = oe;
    endtask

    task automatic pulse_prog();
        #2 prog_clk = 1'b1;
        #2 prog_clk = 1'b0;
    endtask

    // Leaves prog_en high; the caller decides when the fabric goes live.
    task automatic load_img();
        prog_en = 1'b1;
        for (int unsigned i = 0; i < 1480; i++) begin
            prog_in = img[i];
            pulse_prog();
        end
        prog_in = 1'b0;
    endtask

    task automatic cfg_xor();
        img = '0;
        set_cell(0, 16'h6666, 0, 1, 52, 52, 1'b0);
        set_pad(2, 20, 1'b1);
        load_img();
        prog_en = 1'b0;
        #2;
    endtask

    logic [3:0]  xor_exp;
    logic [39:0] chunk_got;
    logic [39:0] chunk_exp;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        prog_clk = 1'b0;
        prog_en  = 1'b0;
        prog_in  = 1'b0;
        tb_drv   = '0;
        tb_oe    = '0;
        img      = '0;
        xor_exp  = 4'b0110;
        #12;

        // Reset state, and reset overriding prog_clk
        check("reset_prog_out", 64'(prog_out), 64'd0);
        check("reset_pads", 64'(io), 64'hFFFFF);
        prog_en = 1'b1;
        prog_in = 1'b1;
        repeat (3) pulse_prog();
        check("reset_hold_chain", 64'(prog_out), 64'd0);
        prog_en = 1'b0;
        prog_in = 1'b0;
        rst     = 1'b0;
        #2;
        check("idle_pads", 64'(io), 64'hFFFFF);

        // Chain readback: pattern 1,1,0 repeating, then flush with zeros
        prog_en = 1'b1;
        for (int unsigned i = 0; i < 1480; i++) begin
            prog_in = ((i % 3) != 2);
            pulse_prog();
        end
        prog_in = 1'b0;
        for (int unsigned c = 0; c < 37; c++) begin
            for (int unsigned b = 0; b < 40; b++) begin
                #1;
                chunk_got[b] = prog_out;
                chunk_exp[b] = (((40*c + b) % 3) != 2);
                pulse_prog();
            end
            check($sformatf("readback_%0d", c), 64'(chunk_got), 64'(chunk_exp));
        end
        #1;
        check("readback_drained", 64'(prog_out), 64'd0);
        prog_en = 1'b0;

        // Combinational XOR on pad 2
        do_reset();
        cfg_xor();
        tb_oe = 20'h00003;
        for (int unsigned v = 0; v < 4; v++) begin
            tb_drv[1:0] = 2'(v);
            #2;
            check($sformatf("xor_%0d", v), 64'(io[2]), 64'(xor_exp[v]));
        end
        check("xor_unused_pad_hiz", 64'(io[3]), 64'd1);

        // Pad disable while prog_en=1: every pad drives constant 0
        tb_oe = '0;
        do_reset();
        img = '0;
        for (int unsigned p = 0; p < 20; p++) set_pad(p, 52, 1'b1);
        load_img();
        prog_en = 1'b0;
        #2;
        check("pads_driven", 64'(io), 64'd0);
        prog_en = 1'b1;
        #2;
        check("pads_disabled", 64'(io), 64'hFFFFF);
        prog_en = 1'b0;
        #2;
        check("pads_return", 64'(io), 64'd0);

        // Reset between clock edges with the XOR design live
        do_reset();
        cfg_xor();
        tb_drv = '0;
        tb_oe  = 20'h00003;
        #2;
        check("rstmid_before", 64'(io[2]), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_pad_hiz", 64'(io[2]), 64'd1);
        check("rstmid_prog_out", 64'(prog_out), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid_stays_hiz", 64'(io[2]), 64'd1);
        cfg_xor();
        check("rstmid_reprog", 64'(io[2]), 64'd0);
        tb_oe = '0;

        // 4-bit ripple adder: a on pads 0-3, b on pads 4-7, sum on pads 8-12
        do_reset();
        img = '0;
        set_cell(0, 16'h6666, 0, 4, 52, 52, 1'b0);
        set_cell(1, 16'h8888, 0, 4, 52, 52, 1'b0);
        for (int unsigned i = 1; i < 4; i++) begin
            set_cell(2*i,   16'h9696, i, 4 + i, 20 + 2*i - 1, 52, 1'b0);
            set_cell(2*i+1, 16'hE8E8, i, 4 + i, 20 + 2*i - 1, 52, 1'b0);
        end
        for (int unsigned i = 0; i < 4; i++) set_pad(8 + i, 20 + 2*i, 1'b1);
        set_pad(12, 27, 1'b1);
        load_img();
        prog_en = 1'b0;
        tb_oe   = 20'h000FF;
        for (int unsigned a = 0; a < 16; a++) begin
            for (int unsigned b = 0; b < 16; b++) begin
                tb_drv[3:0] = 4'(a);
                tb_drv[7:4] = 4'(b);
                #2;
                check($sformatf("adder_%0d_%0d", a, b), 64'(io[12:8]), 64'(a + b));
            end
        end
        tb_oe = '0;

`ifdef FPGAV2_CELL_FF_EN
        // Toggle flop on pad 3, then reset while it runs
        do_reset();
        img = '0;
        set_cell(0, 16'h5555, 20, 52, 52, 52, 1'b1);
        set_pad(3, 20, 1'b1);
        load_img();
        @(negedge clk);
        prog_en = 1'b0;
        #1;
        check("toggle_0", 64'(io[3]), 64'd0);
        for (int unsigned n = 1; n < 5; n++) begin
            @(negedge clk);
            #1;
            check($sformatf("toggle_%0d", n), 64'(io[3]), 64'(n % 2));
        end
        rst = 1'b1;
        #1;
        check("toggle_rst_hiz", 64'(io[3]), 64'd1);
        check("toggle_rst_prog_out", 64'(prog_out), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("toggle_rst_stays_hiz", 64'(io[3]), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
